uart_debug_sequencer: RTL and testbench
=======================================

UART_DEBUG_SEQUENCER -- requirements
Module: uart_debug_sequencer

Interface
REQ-001 Parameter addr_bits, default 4, is the width of dump_addr.
REQ-002 Parameter dump_bytes, default 16, is the byte count of one dump; legal range 1..2^addr_bits.
REQ-003 clock  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 rx_empty  in  1  empty flag of the receive FIFO.
REQ-006 rx_data  in  8  head byte of the receive FIFO, valid whenever rx_empty=0.
REQ-007 rx_read_next  out  1  one-cycle pop strobe to the receive FIFO.
REQ-008 tx_full  in  1  full flag of the transmit FIFO.
REQ-009 tx_data  out  8  byte presented to the transmit FIFO.
REQ-010 tx_write  out  1  one-cycle push strobe to the transmit FIFO.
REQ-011 dump_addr  out  addr_bits  index into the datapath debug register bank.
REQ-012 dump_data  in  8  combinational read of the debug bank at dump_addr.
REQ-013 pipe_enable  out  1  clock enable for the datapath pipeline.
REQ-014 halted  out  1  high when the pipeline is not in free-run mode.

Function
REQ-015 The FSM SHALL have the states IDLE, DECODE, STEP, ACK, NAK and DUMP.
REQ-016 IDLE with rx_empty=0: latch rx_data into cmd, assert rx_read_next for that cycle only, go to DECODE; with rx_empty=1, stay and keep rx_read_next=0.
REQ-017 DECODE (1 cycle) dispatches on cmd:
  - 0x53 'S' -> STEP
  - 0x52 'R' -> set running=1, go to ACK
  - 0x48 'H' -> clear running=0, go to ACK
  - 0x44 'D' -> clear dump counter, go to DUMP
  - any other value -> NAK
REQ-018 STEP (1 cycle) SHALL assert step_pulse when running=0, then go to ACK; with running=1 the step is a no-op that still produces ACK.
REQ-019 pipe_enable SHALL equal (running AND state!=DUMP) OR step_pulse, so that a dump always sees a frozen pipeline.
REQ-020 ACK SHALL hold while tx_full=1; on the first cycle with tx_full=0 it asserts tx_write=1 with tx_data=0x06, then goes to IDLE.
REQ-021 NAK SHALL behave as ACK, but with tx_data=0x15.
REQ-022 DUMP: dump_addr equals the dump counter.
  - Each cycle with tx_full=0: tx_write=1, tx_data=dump_data, counter increments.
  - Each cycle with tx_full=1: tx_write=0 and the counter holds.
  - After the write at counter=dump_bytes-1: go to IDLE; no ACK follows a dump.
REQ-023 The dump counter SHALL be addr_bits+1 wide to avoid wrap at dump_bytes=2^addr_bits; dump_addr is its low addr_bits bits.
REQ-024 tx_write SHALL never be asserted while tx_full=1, and rx_read_next never while rx_empty=1, because the FIFOs overwrite when full and must not be popped when empty.
REQ-025 Outside ACK, NAK and DUMP, tx_data SHALL be 0x00 and tx_write 0; outside DUMP, dump_addr SHALL be 0.
REQ-026 halted SHALL equal NOT running.
REQ-027 Latency: a byte accepted in IDLE at cycle N produces ACK/NAK tx_write at cycle N+2 (N+3 for 'S') when tx_full=0; the first dump byte is written at N+2.
REQ-028 Commands arriving during processing SHALL remain in the receive FIFO, with no loss and no reordering.

Reset
REQ-029 While reset=0: state=IDLE, running=0, cmd=0x00, counter=0.
REQ-030 While reset=0: rx_read_next=0, tx_write=0, tx_data=0x00, pipe_enable=0, dump_addr=0, halted=1.
REQ-031 Reset asserted mid-DUMP or mid-ACK SHALL abort with no further strobes, and operation resumes in IDLE after release.

Verification
REQ-032 'S' with tx_full=0 -> one rx_read_next pulse, exactly one pipe_enable cycle, then tx_write with 0x06.
REQ-033 'R' then 'H' -> pipe_enable high continuously from the 'R' DECODE+1 until the 'H' DECODE, then low; two 0x06 bytes sent; halted tracks running.
REQ-034 'D' with dump_data=0xA0+addr and tx_full toggling every other cycle -> 16 writes of 0xA0..0xAF in order, none while full, pipe_enable=0 throughout.
REQ-035 Byte 0x7F -> one tx_write of 0x15; running is unchanged.
REQ-036 ACK pending with tx_full=1 for 5 cycles -> no tx_write during those cycles, a single 0x06 on the first cycle tx_full=0, and queued 'S' bytes processed afterwards in order.
REQ-037 reset=0 asserted at dump byte 7 -> all outputs at reset values immediately; after release, 'S' is handled normally.

Source files
------------

// File: rtl/uart_debug_sequencer.sv
// uart_debug_sequencer: UART command sequencer for step/run/halt and debug-bank dump
module uart_debug_sequencer #(
  parameter int addr_bits = 4,
  parameter int dump_bytes = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_empty,
  input  logic [7:0]           rx_data,
  output logic                 rx_read_next,
  input  logic                 tx_full,
  output logic [7:0]           tx_data,
  output logic                 tx_write,
  output logic [addr_bits-1:0] dump_addr,
  input  logic [7:0]           dump_data,
  output logic                 pipe_enable,
  output logic                 halted
);
  typedef enum logic [2:0] {IDLE, DECODE, STEP, ACK, NAK, DUMP} state_t;
  localparam logic [addr_bits:0] last = (addr_bits+1)'(dump_bytes - 1);
  state_t state, state_nxt;
  logic running, running_nxt, step_pulse;
  logic [7:0] cmd, cmd_nxt;
  logic [addr_bits:0] cnt, cnt_nxt;
  // state, run flag, latched command and dump counter
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      running <= 1'b0;
      cmd <= 8'h00;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      running <= running_nxt;
      cmd <= cmd_nxt;
      cnt <= cnt_nxt;
    end
  // next state and strobes; FIFO strobes are gated by their flags so nothing overflows or underflows
  always_comb begin
    state_nxt = state;
    running_nxt = running;
    cmd_nxt = cmd;
    cnt_nxt = cnt;
    rx_read_next = 1'b0;
    tx_write = 1'b0;
    tx_data = 8'h00;
    step_pulse = 1'b0;
    case (state)
      IDLE: if (!rx_empty && reset) begin
        rx_read_next = 1'b1;
        cmd_nxt = rx_data;
        state_nxt = DECODE;
      end
      DECODE: case (cmd)
        8'h53: state_nxt = STEP;
        8'h52: begin
          running_nxt = 1'b1;
          state_nxt = ACK;
        end
        8'h48: begin
          running_nxt = 1'b0;
          state_nxt = ACK;
        end
        8'h44: begin
          cnt_nxt = '0;
          state_nxt = DUMP;
        end
        default: state_nxt = NAK;
      endcase
      STEP: begin
        step_pulse = !running;
        state_nxt = ACK;
      end
      ACK, NAK: begin
        tx_data = state == ACK ? 8'h06 : 8'h15;
        tx_write = !tx_full;
        state_nxt = tx_full ? state : IDLE;
      end
      DUMP: begin
        tx_data = dump_data;
        tx_write = !tx_full;
        if (!tx_full) begin
          cnt_nxt = cnt + 1'b1;
          state_nxt = cnt == last ? IDLE : DUMP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign pipe_enable = (running && state != DUMP) || step_pulse;
  assign halted = !running;
  assign dump_addr = state == DUMP ? cnt[addr_bits-1:0] : '0;
endmodule

// File: tb/tb_uart_debug_sequencer.sv
// tb_uart_debug_sequencer: FIFO-model bench with vector table, directed corners and random command streams
module tb_uart_debug_sequencer;
  logic clock = 1'b0, reset = 1'b0, rx_empty = 1'b1, tx_full = 1'b0;
  logic [7:0] rx_data = 8'h00, dump_data, tx_data;
  logic rx_read_next, tx_write, pipe_enable, halted;
  logic [3:0] dump_addr;
  logic [7:0] bank [16];
  logic [7:0] rx_q [$];
  logic [7:0] tx_got [$];
  int total = 0, bad = 0, pe_cnt = 0, rd_cnt = 0, viol = 0;

  uart_debug_sequencer dut (
    .clock(clock), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
    .rx_read_next(rx_read_next), .tx_full(tx_full), .tx_data(tx_data),
    .tx_write(tx_write), .dump_addr(dump_addr), .dump_data(dump_data),
    .pipe_enable(pipe_enable), .halted(halted)
  );

  assign dump_data = bank[dump_addr];
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_rx();
    rx_empty = rx_q.size() == 0;
    rx_data = rx_empty ? 8'h00 : rx_q[0];
  endtask

  // one clock: set inputs, observe strobes mid-cycle, then apply FIFO effects after the edge
  task automatic tick(input logic f);
    logic rd, wr;
    logic [7:0] d;
    tx_full = f;
    drive_rx();
    @(negedge clock);
    rd = rx_read_next;
    wr = tx_write;
    d = tx_data;
    if (pipe_enable) pe_cnt++;
    if (rd) rd_cnt++;
    if (wr && tx_full) viol++;
    if (rd && rx_empty) viol++;
    @(posedge clock);
    #1;
    if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
    if (wr) tx_got.push_back(d);
    drive_rx();
  endtask

  task automatic run_cmd(input logic [7:0] c, output int lat, output int pe, output int rd, output int b);
    int n0, k;
    n0 = tx_got.size();
    k = 0;
    pe_cnt = 0;
    rd_cnt = 0;
    rx_q.push_back(c);
    while (tx_got.size() == n0 && k < 20) begin
      tick(1'b0);
      k++;
    end
    lat = k - 1;
    pe = pe_cnt;
    rd = rd_cnt;
    b = tx_got.size() > n0 ? int'(tx_got[n0]) : -1;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] b;
    int lat;
    int pe;
    logic h;
  } vec_t;
  vec_t v [8];

  initial begin
    int lat, pe, rd, b, k, first, n, errs, cyc;
    logic model_run;
    logic [7:0] c;
    logic [7:0] exp_q [$];
    logic [7:0] pend [$];
    v[0] = '{8'h53, 8'h06, 3, 1, 1'b1};
    v[1] = '{8'h7F, 8'h15, 2, 0, 1'b1};
    v[2] = '{8'h52, 8'h06, 2, 1, 1'b0};
    v[3] = '{8'h53, 8'h06, 3, 4, 1'b0};
    v[4] = '{8'h7F, 8'h15, 2, 3, 1'b0};
    v[5] = '{8'h48, 8'h06, 2, 2, 1'b1};
    v[6] = '{8'h00, 8'h15, 2, 0, 1'b1};
    v[7] = '{8'hFF, 8'h15, 2, 0, 1'b1};
    for (int i = 0; i < 16; i++) bank[i] = 8'hA0 + 8'(i);

    rx_q.push_back(8'h53);
    drive_rx();
    #12;
    check("rst_rx_read_next", int'(rx_read_next), 0);
    check("rst_tx_write", int'(tx_write), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_pipe_enable", int'(pipe_enable), 0);
    check("rst_dump_addr", int'(dump_addr), 0);
    check("rst_halted", int'(halted), 1);
    rx_q.delete();
    drive_rx();
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(v[i].cmd, lat, pe, rd, b);
      check($sformatf("vec%0d_byte", i), b, int'(v[i].b));
      check($sformatf("vec%0d_latency", i), lat, v[i].lat);
      check($sformatf("vec%0d_pipe_cycles", i), pe, v[i].pe);
      check($sformatf("vec%0d_pops", i), rd, 1);
      check($sformatf("vec%0d_halted", i), int'(halted), int'(v[i].h));
    end

    tx_got.delete();
    pe_cnt = 0;
    viol = 0;
    first = -1;
    k = 0;
    rx_q.push_back(8'h44);
    while (tx_got.size() < 16 && k < 100) begin
      n = tx_got.size();
      tick(k % 2 == 1);
      if (first < 0 && tx_got.size() > n) first = k;
      k++;
    end
    for (int i = 0; i < 3; i++) tick(1'b0);
    check("dump_first_write_cycle", first, 2);
    check("dump_count", tx_got.size(), 16);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (i >= tx_got.size() || tx_got[i] != 8'hA0 + 8'(i)) errs++;
    check("dump_bytes_wrong", errs, 0);
    check("dump_pipe_enable_cycles", pe_cnt, 0);
    check("dump_full_violations", viol, 0);

    tx_got.delete();
    pe_cnt = 0;
    viol = 0;
    rx_q.push_back(8'h53);
    rx_q.push_back(8'h53);
    rx_q.push_back(8'h53);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("ackhold_no_write", tx_got.size(), 0);
    check("ackhold_queued", rx_q.size(), 2);
    tick(1'b0);
    check("ackhold_release_write", tx_got.size(), 1);
    k = 0;
    while (tx_got.size() < 3 && k < 40) begin
      tick(1'b0);
      k++;
    end
    check("ackhold_total", tx_got.size(), 3);
    errs = 0;
    foreach (tx_got[i]) if (tx_got[i] != 8'h06) errs++;
    check("ackhold_bytes_wrong", errs, 0);
    check("ackhold_pipe_cycles", pe_cnt, 3);
    check("ackhold_violations", viol, 0);

    tx_got.delete();
    rx_q.push_back(8'h44);
    k = 0;
    while (tx_got.size() < 7 && k < 50) begin
      tick(1'b0);
      k++;
    end
    check("midreset_dump_addr_before", int'(dump_addr), 7);
    reset = 1'b0;
    #1;
    check("midreset_tx_write", int'(tx_write), 0);
    check("midreset_tx_data", int'(tx_data), 0);
    check("midreset_dump_addr", int'(dump_addr), 0);
    check("midreset_pipe_enable", int'(pipe_enable), 0);
    check("midreset_halted", int'(halted), 1);
    tick(1'b0);
    tick(1'b0);
    check("midreset_no_more_writes", tx_got.size(), 7);
    reset = 1'b1;
    run_cmd(8'h53, lat, pe, rd, b);
    check("postreset_byte", b, 8'h06);
    check("postreset_latency", lat, 3);
    check("postreset_pipe_cycles", pe, 1);

    for (int i = 0; i < 16; i++) bank[i] = 8'($urandom_range(0, 255));
    tx_got.delete();
    viol = 0;
    model_run = 1'b0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: c = 8'h53;
        1: c = 8'h52;
        2: c = 8'h48;
        3: c = 8'h44;
        default: c = 8'($urandom_range(0, 255));
      endcase
      pend.push_back(c);
      if (c == 8'h44) for (int j = 0; j < 16; j++) exp_q.push_back(bank[j]);
      else if (c == 8'h53 || c == 8'h52 || c == 8'h48) exp_q.push_back(8'h06);
      else exp_q.push_back(8'h15);
      if (c == 8'h52) model_run = 1'b1;
      if (c == 8'h48) model_run = 1'b0;
    end
    cyc = 0;
    while (tx_got.size() < exp_q.size() && cyc < 20000) begin
      if (pend.size() > 0 && $urandom_range(0, 3) == 0) rx_q.push_back(pend.pop_front());
      tick($urandom_range(0, 2) == 0);
      cyc++;
    end
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("rand_count", tx_got.size(), exp_q.size());
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= tx_got.size() || tx_got[i] != exp_q[i]) errs++;
    check("rand_stream_wrong", errs, 0);
    check("rand_halted", int'(halted), int'(!model_run));
    check("rand_violations", viol, 0);
    check("rand_rx_drained", rx_q.size() + pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
